// File: rtl/dac_output_stage_if.sv
// Signal bundle between the DSP calculation stage, the DAC and the feedback output stage.
interface dac_output_stage_if #(
  parameter int DAC_WIDTH = 14
);
  logic signed [DAC_WIDTH:0]   pout;
  logic                        dsp_oflow;
  logic                        fb_cond;
  logic                        dac_clk_in;
  logic                        fb_en;
  logic                        store_strb;
  logic signed [DAC_WIDTH-1:0] dac_offset;
  logic        [DAC_WIDTH-1:0] dac_data;
  logic                        dac_wr;
  logic                        sat_flag;
  logic        [7:0]           oflow_cnt;
  logic                        trip;

  modport master (
    output pout, dsp_oflow, fb_cond, dac_clk_in, fb_en, store_strb, dac_offset,
    input  dac_data, dac_wr, sat_flag, oflow_cnt, trip
  );

  modport slave (
    input  pout, dsp_oflow, fb_cond, dac_clk_in, fb_en, store_strb, dac_offset,
    output dac_data, dac_wr, sat_flag, oflow_cnt, trip
  );
endinterface

// File: rtl/dac_output_stage.sv
// Bunch-by-bunch feedback DAC output stage: capture, offset, saturate, drive, overflow trip.
// Define FB_TRIP_EN to build the TRIP state and consecutive-overflow counter.
module dac_output_stage #(
  parameter int DAC_WIDTH   = 14,
  parameter int OFLOW_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dac_output_stage_if.slave  bus
);

  if (DAC_WIDTH != 14) begin : g_bad_width
    $error("DAC_WIDTH is fixed at 14 in this revision");
  end
  if (OFLOW_LIMIT < 1 || OFLOW_LIMIT > 255) begin : g_bad_limit
    $error("OFLOW_LIMIT must lie in 1..255");
  end

  localparam int SW = DAC_WIDTH + 2;
  localparam logic signed [SW-1:0]  CODE_MAX = SW'(2 ** (DAC_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0]  CODE_MIN = SW'(-(2 ** (DAC_WIDTH - 1)));
  localparam logic [DAC_WIDTH-1:0]  MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DRIVE
`ifdef FB_TRIP_EN
    , S_TRIP
`endif
  } state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  rst_sync_q;
  logic                        fb_cond_q, dac_clk_q, store_q;
  logic signed [DAC_WIDTH:0]   pout_q;
  logic                        oflow_q;
  logic [DAC_WIDTH-1:0]        dac_data_q, dac_data_d;
  logic                        dac_wr_q, dac_wr_d;
  logic                        sat_q, sat_d;
  logic [7:0]                  oflow_cnt_q, oflow_cnt_d;

  logic run, enable, fb_rise, dac_clk_fall, store_rise, capture_fire, quiet;
  logic signed [SW-1:0]        sum;
  logic [DAC_WIDTH-1:0]        code, new_data;
  logic                        sat_hit;

  assign run          = rst_sync_q[1];
  assign enable       = bus.fb_en & bus.store_strb;
  assign fb_rise      = bus.fb_cond & ~fb_cond_q;
  assign dac_clk_fall = ~bus.dac_clk_in & dac_clk_q;
  assign store_rise   = bus.store_strb & ~store_q;
  assign capture_fire = (state_q == S_CAPTURE) & enable;
  assign sum          = SW'(pout_q) + SW'(bus.dac_offset);

  // Clip the widened sum to the DAC code range; overflowed samples go to full scale by sign.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sat_hit = 1'b0;
    code    = sum[DAC_WIDTH-1:0];
    if (sum > CODE_MAX) begin
      sat_hit = 1'b1;
      code    = CODE_MAX[DAC_WIDTH-1:0];
    end else if (sum < CODE_MIN) begin
      sat_hit = 1'b1;
      code    = CODE_MIN[DAC_WIDTH-1:0];
    end
    new_data = {~code[DAC_WIDTH-1], code[DAC_WIDTH-2:0]};
    if (oflow_q) begin
      sat_hit  = 1'b0;
      new_data = pout_q[DAC_WIDTH] ? '0 : '1;
    end
  end

`ifdef FB_TRIP_EN
  logic [7:0] consec_q, consec_d;
  logic       trip_hit;

  assign trip_hit = consec_q >= 8'(OFLOW_LIMIT);
  assign quiet    = (state_d == S_IDLE) || (state_d == S_TRIP);
  assign bus.trip = (state_q == S_TRIP);

  always_comb begin
    consec_d = consec_q;
    if (store_rise)        consec_d = '0;
    else if (capture_fire) consec_d = !oflow_q ? 8'd0 : (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
  end
`else
  assign quiet    = (state_d == S_IDLE);
  assign bus.trip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (enable) state_d = S_WAIT;
        S_WAIT:    if (!enable) state_d = S_IDLE;
                   else if (fb_rise) state_d = S_CAPTURE;
        S_CAPTURE: state_d = enable ? S_DRIVE : S_IDLE;
        S_DRIVE:   if (!enable) state_d = S_IDLE;
`ifdef FB_TRIP_EN
                   else if (dac_clk_fall) state_d = trip_hit ? S_TRIP : S_WAIT;
        S_TRIP:    if (!bus.store_strb) state_d = S_IDLE;
`else
                   else if (dac_clk_fall) state_d = S_WAIT;
`endif
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dac_data_d  = dac_data_q;
    dac_wr_d    = 1'b0;
    sat_d       = 1'b0;
    oflow_cnt_d = oflow_cnt_q;
    if (quiet) begin
      dac_data_d = MIDSCALE;
    end else if (capture_fire) begin
      dac_data_d = new_data;
      sat_d      = sat_hit;
    end
    if (state_q == S_DRIVE && state_d == S_DRIVE) dac_wr_d = bus.dac_clk_in;
    if (store_rise) oflow_cnt_d = '0;
    else if (capture_fire && oflow_q && oflow_cnt_q != 8'hFF) oflow_cnt_d = oflow_cnt_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments; the capture registers are reset too,
  // so the first DAC code never depends on power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rst_sync_q  <= '0;
      fb_cond_q   <= 1'b0;
      dac_clk_q   <= 1'b0;
      store_q     <= 1'b0;
      pout_q      <= '0;
      oflow_q     <= 1'b0;
      dac_data_q  <= MIDSCALE;
      dac_wr_q    <= 1'b0;
      sat_q       <= 1'b0;
      oflow_cnt_q <= '0;
`ifdef FB_TRIP_EN
      consec_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      fb_cond_q   <= bus.fb_cond;
      dac_clk_q   <= bus.dac_clk_in;
      store_q     <= bus.store_strb;
      if (state_q == S_WAIT && state_d == S_CAPTURE) begin
        pout_q  <= bus.pout;
        oflow_q <= bus.dsp_oflow;
      end
      dac_data_q  <= dac_data_d;
      dac_wr_q    <= dac_wr_d;
      sat_q       <= sat_d;
      oflow_cnt_q <= oflow_cnt_d;
`ifdef FB_TRIP_EN
      consec_q    <= consec_d;
`endif
    end
  end

  assign bus.dac_data  = dac_data_q;
  assign bus.dac_wr    = dac_wr_q;
  assign bus.sat_flag  = sat_q;
  assign bus.oflow_cnt = oflow_cnt_q;

endmodule

// File: tb/tb_dac_output_stage.sv
// Directed, table-driven bench for dac_output_stage (trip checks follow FB_TRIP_EN).
module tb_dac_output_stage;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  logic [13:0] prev_data = 14'h2000;

  dac_output_stage_if #(.DAC_WIDTH(14)) bus ();

  dac_output_stage #(.DAC_WIDTH(14), .OFLOW_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  typedef struct {
    logic signed [14:0] pout;
    logic               oflow;
    logic signed [13:0] off;
    logic [13:0]        exp_data;
    logic               exp_sat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bunch: fb_cond high for two edges, then dac_clk_in high for two edges.
  task automatic bunch(input string tag, input logic signed [14:0] p, input logic of,
                       input logic signed [13:0] off, input logic [13:0] exp_data,
                       input logic exp_sat, input logic exp_wr);
    bus.pout = p; bus.dsp_oflow = of; bus.dac_offset = off; bus.fb_cond = 1'b1;
    tick();
    check({tag, " data before latency"}, 32'(bus.dac_data), 32'(prev_data));
    check({tag, " wr idle"}, 32'(bus.dac_wr), 32'd0);
    tick();
    bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b1;
    check({tag, " data"}, 32'(bus.dac_data), 32'(exp_data));
    check({tag, " sat"}, 32'(bus.sat_flag), 32'(exp_sat));
    check({tag, " wr before"}, 32'(bus.dac_wr), 32'd0);
    tick();
    check({tag, " wr 1st"}, 32'(bus.dac_wr), 32'(exp_wr));
    check({tag, " sat one cycle"}, 32'(bus.sat_flag), 32'd0);
    tick();
    bus.dac_clk_in = 1'b0;
    check({tag, " wr 2nd"}, 32'(bus.dac_wr), 32'(exp_wr));
    tick();
    check({tag, " wr end"}, 32'(bus.dac_wr), 32'd0);
    tick();
    prev_data = exp_data;
  endtask

  initial begin
    vecs[0]  = '{15'sd100,    1'b0, -14'sd20,  14'h2050, 1'b0};
    vecs[1]  = '{15'sd16383,  1'b0, 14'sd100,  14'h3FFF, 1'b1};
    vecs[2]  = '{-15'sd5,     1'b1, 14'sd0,    14'h0000, 1'b0};
    vecs[3]  = '{15'sd0,      1'b0, 14'sd0,    14'h2000, 1'b0};
    vecs[4]  = '{15'h4000,    1'b0, 14'sd0,    14'h0000, 1'b1};
    vecs[5]  = '{15'sd8191,   1'b0, 14'sd0,    14'h3FFF, 1'b0};
    vecs[6]  = '{15'sd8192,   1'b0, 14'sd0,    14'h3FFF, 1'b1};
    vecs[7]  = '{-15'sd8192,  1'b0, 14'sd0,    14'h0000, 1'b0};
    vecs[8]  = '{-15'sd8193,  1'b0, 14'sd0,    14'h0000, 1'b1};
    vecs[9]  = '{15'sd500,    1'b1, -14'sd300, 14'h3FFF, 1'b0};
    vecs[10] = '{15'sd1000,   1'b0, 14'h2000,  14'h03E8, 1'b0};
    vecs[11] = '{-15'sd1,     1'b0, 14'sd0,    14'h1FFF, 1'b0};
    vecs[12] = '{15'sd0,      1'b1, 14'sd0,    14'h3FFF, 1'b0};
    vecs[13] = '{15'sd8000,   1'b0, 14'sd191,  14'h3FFF, 1'b0};
    vecs[14] = '{-15'sd8000,  1'b0, -14'sd193, 14'h0000, 1'b1};
    vecs[15] = '{15'sd4000,   1'b0, 14'sd8191, 14'h3FFF, 1'b1};

    rst_n = 1'b0;
    bus.pout = '0; bus.dsp_oflow = 1'b0; bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b0;
    bus.fb_en = 1'b0; bus.store_strb = 1'b0; bus.dac_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dac_data", 32'(bus.dac_data), 32'h2000);
    check("reset dac_wr", 32'(bus.dac_wr), 32'd0);
    check("reset sat_flag", 32'(bus.sat_flag), 32'd0);
    check("reset oflow_cnt", 32'(bus.oflow_cnt), 32'd0);
    check("reset trip", 32'(bus.trip), 32'd0);

    rst_n = 1'b1;
    bus.fb_en = 1'b1; bus.store_strb = 1'b1;
    repeat (4) tick();
    check("armed dac_data midscale", 32'(bus.dac_data), 32'h2000);

    for (int i = 0; i < 16; i++) begin
      bunch($sformatf("vec%0d", i), vecs[i].pout, vecs[i].oflow, vecs[i].off,
            vecs[i].exp_data, vecs[i].exp_sat, 1'b1);
      if (vecs[i].oflow) exp_cnt++;
      check($sformatf("vec%0d oflow_cnt", i), 32'(bus.oflow_cnt), 32'(exp_cnt));
    end

    // fb_cond rising while in DRIVE must not start a new capture.
    bus.pout = 15'sd200; bus.dsp_oflow = 1'b0; bus.dac_offset = '0; bus.fb_cond = 1'b1;
    tick();
    tick();
    bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b1; bus.pout = -15'sd3000;
    check("drive-ignore data", 32'(bus.dac_data), 32'h20C8);
    tick();
    bus.fb_cond = 1'b1;
    check("drive-ignore wr 1st", 32'(bus.dac_wr), 32'd1);
    tick();
    bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b0;
    check("drive-ignore wr 2nd", 32'(bus.dac_wr), 32'd1);
    repeat (3) tick();
    check("drive-ignore data held", 32'(bus.dac_data), 32'h20C8);
    check("drive-ignore wr quiet", 32'(bus.dac_wr), 32'd0);

    // store_strb falling mid-DRIVE aborts the write; rising again clears the counter.
    bus.pout = -15'sd100; bus.fb_cond = 1'b1;
    tick();
    tick();
    bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b1;
    check("abort data", 32'(bus.dac_data), 32'h1F9C);
    tick();
    check("abort wr before", 32'(bus.dac_wr), 32'd1);
    bus.store_strb = 1'b0;
    tick();
    check("abort wr", 32'(bus.dac_wr), 32'd0);
    check("abort midscale", 32'(bus.dac_data), 32'h2000);
    bus.dac_clk_in = 1'b0;
    tick();
    bus.store_strb = 1'b1;
    tick();
    exp_cnt = 0;
    check("store rise clears oflow_cnt", 32'(bus.oflow_cnt), 32'(exp_cnt));
    tick();
    prev_data = 14'h2000;

    for (int k = 0; k < 4; k++) begin
      bunch($sformatf("ovf%0d", k), 15'sd7, 1'b1, 14'sd0, 14'h3FFF, 1'b0, 1'b1);
      exp_cnt++;
    end
`ifdef FB_TRIP_EN
    check("trip set", 32'(bus.trip), 32'd1);
    check("trip midscale", 32'(bus.dac_data), 32'h2000);
    check("trip oflow_cnt", 32'(bus.oflow_cnt), 32'(exp_cnt));
    prev_data = 14'h2000;
    bunch("in trip", 15'sd100, 1'b0, -14'sd20, 14'h2000, 1'b0, 1'b0);
    bus.fb_en = 1'b0;
    tick();
    tick();
    bus.fb_en = 1'b1;
    tick();
    check("trip survives fb_en", 32'(bus.trip), 32'd1);
    bus.store_strb = 1'b0;
    tick();
    check("trip cleared", 32'(bus.trip), 32'd0);
    check("idle midscale", 32'(bus.dac_data), 32'h2000);
    bus.store_strb = 1'b1;
    tick();
    tick();
    exp_cnt = 0;
    check("trip clear oflow_cnt", 32'(bus.oflow_cnt), 32'(exp_cnt));
    bunch("after clear", 15'sd100, 1'b0, -14'sd20, 14'h2050, 1'b0, 1'b1);
`else
    check("no trip", 32'(bus.trip), 32'd0);
    check("no trip data", 32'(bus.dac_data), 32'h3FFF);
    check("no trip oflow_cnt", 32'(bus.oflow_cnt), 32'(exp_cnt));
    bunch("no trip next", 15'sd100, 1'b0, -14'sd20, 14'h2050, 1'b0, 1'b1);
`endif

    // Asynchronous reset during DRIVE, then an fb_cond window too soon after release.
    bus.pout = 15'sd300; bus.dsp_oflow = 1'b0; bus.dac_offset = '0; bus.fb_cond = 1'b1;
    tick();
    tick();
    bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b1;
    check("pre-reset data", 32'(bus.dac_data), 32'h212C);
    tick();
    check("pre-reset wr", 32'(bus.dac_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset wr", 32'(bus.dac_wr), 32'd0);
    check("async reset data", 32'(bus.dac_data), 32'h2000);
    check("async reset oflow_cnt", 32'(bus.oflow_cnt), 32'd0);
    check("async reset trip", 32'(bus.trip), 32'd0);
    bus.dac_clk_in = 1'b0;
    #2 rst_n = 1'b1;
    bus.fb_cond = 1'b1; bus.pout = 15'sd777;
    tick();
    tick();
    bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b1;
    tick();
    tick();
    bus.dac_clk_in = 1'b0;
    check("early window no write", 32'(bus.dac_wr), 32'd0);
    check("early window no capture", 32'(bus.dac_data), 32'h2000);
    tick();
    check("early window data held", 32'(bus.dac_data), 32'h2000);
    tick();
    prev_data = 14'h2000;
    bunch("post reset", 15'sd100, 1'b0, -14'sd20, 14'h2050, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_output_stage.md
DAC_OUTPUT_STAGE -- requirements
Module: dac_output_stage

Interface
REQ-001 Parameter DAC_WIDTH, 14, DAC code width in bits; fixed at 14 for this revision.
REQ-002 Parameter OFLOW_LIMIT, 4, consecutive overflowed captures that cause a trip; legal range 1..255.
REQ-003 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port pout, input, 15, signed feedback sample from the DSP calculation stage.
REQ-006 Port dsp_oflow, input, 1, overflow flag, aligned with pout.
REQ-007 Port fb_cond, input, 1, capture window; high for 2 cycles per bunch.
REQ-008 Port dac_clk_in, input, 1, DAC write window; high for 2 cycles per bunch, after fb_cond.
REQ-009 Port fb_en, input, 1, feedback enable.
REQ-010 Port store_strb, input, 1, high while beam is stored.
REQ-011 Port dac_offset, input, 14, signed static DAC offset.
REQ-012 Port dac_data, output, 14, offset-binary DAC code.
REQ-013 Port dac_wr, output, 1, DAC write strobe.
REQ-014 Port sat_flag, output, 1, one-cycle pulse when a capture saturates.
REQ-015 Port oflow_cnt, output, 8, saturating count of overflowed captures in the current store.
REQ-016 Port trip, output, 1, sticky feedback-trip indicator.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, WAIT, CAPTURE, DRIVE and TRIP.
REQ-018 IDLE SHALL go to WAIT when fb_en=1 and store_strb=1 in the same cycle.
REQ-019 In any state except TRIP, fb_en=0 or store_strb=0 SHALL force IDLE on the next edge.
REQ-020 In TRIP, store_strb=0 SHALL force IDLE on the next edge; fb_en=0 alone SHALL NOT leave TRIP.
REQ-021 Rising-edge detection SHALL use each window input's registered previous value.
REQ-022 WAIT SHALL go to CAPTURE on a fb_cond rising edge, registering pout and dsp_oflow.
REQ-023 CAPTURE SHALL compute pout and dac_offset sign-extended to 16 bits and summed.
REQ-024 The sum SHALL be saturated to [-8192, +8191], and sat_flag SHALL pulse when clipping occurs.
REQ-025 The code SHALL be converted to offset binary by inverting the MSB; CAPTURE SHALL last exactly one cycle, then go to DRIVE.
REQ-026 The new code SHALL appear on dac_data 2 cycles after the fb_cond rising edge.
REQ-027 A captured sample with dsp_oflow=1 SHALL be replaced by full-scale of pout's sign: 0x3FFF if positive, 0x0000 if negative.
REQ-028 A captured sample with dsp_oflow=1 SHALL increment oflow_cnt (saturating at 255) and the consecutive-overflow counter.
REQ-029 A captured sample with dsp_oflow=0 SHALL clear the consecutive-overflow counter.
REQ-030 In DRIVE, dac_wr SHALL equal dac_clk_in delayed by one register, giving a 2-cycle pulse.
REQ-031 A dac_clk_in falling edge SHALL return DRIVE to WAIT.
REQ-032 A fb_cond rising edge that arrives while in DRIVE SHALL be ignored.
REQ-033 The consecutive-overflow counter reaching OFLOW_LIMIT SHALL move the FSM to TRIP after DRIVE completes.
REQ-034 In TRIP and IDLE, dac_data SHALL be midscale 0x2000 and dac_wr SHALL be 0.
REQ-035 trip SHALL be high in TRIP only.
REQ-036 oflow_cnt and the consecutive-overflow counter SHALL clear on a store_strb rising edge.
REQ-037 If a store_strb rising edge coincides with an overflowed capture, the clear SHALL take priority.
REQ-038 A store_strb fall mid-DRIVE SHALL abort dac_wr within 1 cycle and force midscale.

Reset
REQ-039 rst_n=0 SHALL asynchronously set state=IDLE, dac_data=0x2000, dac_wr=0, sat_flag=0, oflow_cnt=0, trip=0, and all internal registers to 0.
REQ-040 rst_n deassertion SHALL be synchronised internally before the FSM leaves IDLE.
REQ-041 The first fb_cond rising edge recognised after reset SHALL be one that occurs at least 2 cycles after rst_n rises.

Configuration
REQ-042 Macro FB_TRIP_EN defined: the TRIP state and consecutive-overflow counter SHALL be present as specified.
REQ-043 Macro FB_TRIP_EN undefined: the TRIP state and consecutive-overflow counter SHALL be absent and trip SHALL be tied to 0.
REQ-044 Macro FB_TRIP_EN undefined: overflowed samples SHALL still saturate and count in oflow_cnt.

Verification
REQ-045 Overflow-free sample: pout=+100, dac_offset=-20, no overflow -> dac_data=0x2050 two cycles after the fb_cond rise; dac_wr is a 2-cycle pulse delayed one cycle from dac_clk_in.
REQ-046 Saturation: pout=+16383, dac_offset=+100 -> dac_data=0x3FFF and sat_flag pulses once.
REQ-047 Negative overflow: pout=-5 with dsp_oflow=1 -> dac_data=0x0000 and oflow_cnt increments.
REQ-048 Trip entry (FB_TRIP_EN): 4 consecutive overflowed bunches -> trip=1, dac_data=0x2000, no further dac_wr; toggling fb_en leaves trip=1.
REQ-049 Trip clear: store_strb low then high after a trip -> IDLE then WAIT, trip=0, oflow_cnt=0.
REQ-050 Reset mid-operation: rst_n asserted during DRIVE -> dac_wr=0 and dac_data=0x2000 immediately, without waiting for a clk edge.
